wait_time_calc: RTL and testbench

//  Sequential successor of the queue wait-time ROM: computes estimated customer wait time

---
 rtl/sbqm_pkg.sv | 21 ++
 rtl/seq_divider.sv | 63 ++++++
 rtl/wait_time_calc.sv | 140 ++++++++++++++
 tb/tb_wait_time_calc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sbqm_pkg.sv
// Shared types and default widths for the bank queue manager slice.
// Consumed by wait_time_calc and its seq_divider datapath.
package sbqm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int PCNT_W_DEF = 3;
    localparam int TCNT_W_DEF = 2;
    localparam int WT_W_DEF   = 5;
    localparam int SVC_T_DEF  = 3;

    // Bits needed for SVC_T*(P+T-1) at the largest P and T the counters can present.
    function automatic int num_width(input int svc_t, input int pcnt_w, input int tcnt_w);
        return $clog2(svc_t * ((1 << pcnt_w) + (1 << tcnt_w) - 2) + 1);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first, NUM_W steps after start.
// quotient/remainder show the values produced by the current step; they are final
// in the cycle where done is high. The caller never starts with a zero divisor.
module seq_divider #(
    parameter int NUM_W = 5,
    parameter int DEN_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             done,
    output logic [NUM_W-1:0] quotient,
    output logic [DEN_W-1:0] remainder
);

    localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

    logic [NUM_W-1:0] shift_q;  // dividend bits shift out as quotient bits shift in
    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic [DEN_W:0]   trial;
    logic             fits;

    // One restoring step: bring down the next dividend bit, subtract if the divisor fits.
    always_comb begin
        trial     = {rem_q, shift_q[NUM_W-1]};
        fits      = (trial >= {1'b0, den_q});
        remainder = fits ? DEN_W'(trial - {1'b0, den_q}) : trial[DEN_W-1:0];
        quotient  = {shift_q[NUM_W-2:0], fits};
        done      = active && (cnt == CNT_W'(NUM_W - 1));
    end

    // Load operands on start, then advance one step per cycle until the last bit.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the datapath registers are reset along with the control bits; they are
        // few, and it keeps every output defined straight out of reset.
        if (rst) begin
            shift_q <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            cnt     <= '0;
            active  <= 1'b0;
        end else if (start) begin
            shift_q <= dividend;
            rem_q   <= '0;
            den_q   <= divisor;
            cnt     <= '0;
            active  <= 1'b1;
        end else if (active) begin
            shift_q <= quotient;
            rem_q   <= remainder;
            cnt     <= cnt + CNT_W'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wait_time_calc.sv
// Estimated customer wait time: wtime = SVC_T*(P+T-1)/T, floor by default,
// saturating at 2^WT_W-1 with ovf set. Valid/ready handshakes on both sides.
// Build option: define ROUND_HALF_UP_EN to round the quotient half-up instead of
// truncating; latency is unchanged.
module wait_time_calc
    import sbqm_pkg::*;
#(
    parameter int PCNT_W = PCNT_W_DEF,
    parameter int TCNT_W = TCNT_W_DEF,
    parameter int SVC_T  = SVC_T_DEF,
    parameter int WT_W   = WT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PCNT_W-1:0] pcount,
    input  logic [TCNT_W-1:0] tcount,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WT_W-1:0]   wtime,
    output logic              ovf,
    output logic              busy
);

    localparam int NUM_W = num_width(SVC_T, PCNT_W, TCNT_W);
    localparam int QX_W  = NUM_W + 1;  // room for the rounding increment
    localparam logic [QX_W-1:0] WT_MAX = QX_W'((1 << WT_W) - 1);

    state_t            state;
    logic              zero_op;
    logic              div_start;
    logic [NUM_W-1:0]  numer;
    logic              div_done;
    logic [NUM_W-1:0]  div_q;
    logic [TCNT_W-1:0] div_rem;
    logic [QX_W-1:0]   q_ext;
    logic              sat;
    logic [WT_W-1:0]   res;

    assign zero_op   = (pcount == '0) || (tcount == '0);
    assign div_start = in_ready && in_valid && !zero_op;
    // Cannot overflow NUM_W: the width is derived from the largest possible product.
    assign numer     = NUM_W'(SVC_T) * (NUM_W'(pcount) + NUM_W'(tcount) - NUM_W'(1));

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (TCNT_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (numer),
        .divisor   (tcount),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_rem)
    );

`ifdef ROUND_HALF_UP_EN
    logic [TCNT_W-1:0] t_lat;

    // Keep the divisor for the half-up test on the final remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_lat <= '0;
        end else if (div_start) begin
            t_lat <= tcount;
        end
    end
`else
    logic unused_rem;
    assign unused_rem = ^div_rem;
`endif

    // Round (optional) then saturate the final quotient into the output width.
    always_comb begin
        // NOTE: every variable gets a value before any condition, so no path through
        // this block can leave one unassigned and infer a latch.
        q_ext = {1'b0, div_q};
`ifdef ROUND_HALF_UP_EN
        if ({div_rem, 1'b0} >= {1'b0, t_lat}) begin
            q_ext = q_ext + QX_W'(1);
        end
`endif
        sat = (q_ext > WT_MAX);
        res = sat ? '1 : WT_W'(q_ext);
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state and outputs are updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            wtime     <= '0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (zero_op) begin
                            wtime     <= '0;
                            ovf       <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (div_done) begin
                        wtime     <= res;
                        ovf       <= sat;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wait_time_calc.sv
// Directed bench for wait_time_calc: default instance (WT_W=5) and a WT_W=4 instance
// sharing the same stimulus, so saturation is exercised in the same run.
// Expected values follow ROUND_HALF_UP_EN when the bench is built with it.
module tb_wait_time_calc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] pcount = '0;
    logic [1:0] tcount = '0;

    logic       in_ready, out_valid, ovf, busy;
    logic [4:0] wtime;
    logic       in_ready4, out_valid4, ovf4, busy4;
    logic [3:0] wtime4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wait_time_calc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pcount    (pcount),
        .tcount    (tcount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wtime     (wtime),
        .ovf       (ovf),
        .busy      (busy)
    );

    wait_time_calc #(.WT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .pcount    (pcount),
        .tcount    (tcount),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .wtime     (wtime4),
        .ovf       (ovf4),
        .busy      (busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: SVC_T=3, wait = 3*(P+T-1)/T, zero when either count is zero.
    function automatic int model_q(input int p, input int t);
        int n;
        int q;
        if (p == 0 || t == 0) return 0;
        n = 3 * (p + t - 1);
        q = n / t;
`ifdef ROUND_HALF_UP_EN
        if (2 * (n % t) >= t) q++;
`endif
        return q;
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen,
    // with edges = rising edges from the accepting edge up to that point (inclusive).
    task automatic issue(input string tag, input int p, input int t, output int edges);
        edges = 0;
        while (!in_ready && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        pcount   = 3'(p);
        tcount   = 2'(t);
        in_valid = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        pcount   = 3'($urandom);
        tcount   = 2'($urandom);
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic expect_result(input string tag, input int q, input int lat, input int edges);
        check({tag, "_latency"}, 32'(edges), 32'(lat));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_wtime"}, 32'(wtime), 32'((q > 31) ? 31 : q));
        check({tag, "_ovf"}, 32'(ovf), 32'(q > 31));
        check({tag, "_out_valid4"}, 32'(out_valid4), 32'd1);
        check({tag, "_wtime4"}, 32'(wtime4), 32'((q > 15) ? 15 : q));
        check({tag, "_ovf4"}, 32'(ovf4), 32'(q > 15));
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ack_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ack_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_ack_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_op(input string tag, input int p, input int t, input int q, input int lat);
        int edges;
        issue(tag, p, t, edges);
        expect_result(tag, q, lat, edges);
        ack(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  edges;
        bit  saw_valid;

        // Reset values
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_wtime", 32'(wtime), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Main function, hand-computed
`ifdef ROUND_HALF_UP_EN
        do_op("p2t2", 2, 2, 5, 6);
`else
        do_op("p2t2", 2, 2, 4, 6);
`endif
        do_op("p7t1", 7, 1, 21, 6);
        do_op("p7t3", 7, 3, 9, 6);
        do_op("p3t3", 3, 3, 5, 6);
        do_op("p1t1", 1, 1, 3, 6);
        do_op("p0t3", 0, 3, 0, 1);
        do_op("p5t0", 5, 0, 0, 1);
        do_op("p6t1", 6, 1, 18, 6);

        // Back-pressure in DONE: result held, new operands ignored
        issue("stall", 7, 3, edges);
        expect_result("stall", 9, 6, edges);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            pcount   = 3'd1;
            tcount   = 2'd1;
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_wtime", 32'(wtime), 32'd9);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        ack("stall");
        do_op("after_stall", 1, 1, 3, 6);

        // Reset in the third CALC cycle
        pcount   = 3'd7;
        tcount   = 2'd1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midcalc_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wtime", 32'(wtime), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst_no_output", 32'(saw_valid), 32'd0);
        do_op("after_rst", 3, 3, 5, 6);

        // Full sweep against the reference
        for (int p = 0; p < 8; p++) begin
            for (int t = 0; t < 4; t++) begin
                do_op($sformatf("sweep_p%0dt%0d", p, t), p, t, model_q(p, t),
                      (p == 0 || t == 0) ? 1 : 6);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
